// File: rtl/updown_sweep_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// updown_sweep_ctrl_pkg
//   Shared definitions for the triangle-sweep sequencer:
//     - default counter/bound width and sweep-count width
//     - controller state encoding
// ---------------------------------------------------------------------------
package updown_sweep_ctrl_pkg;

  localparam int W_DEF  = 4;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/updown_sweep_ctrl_cnt_core.sv
// ---------------------------------------------------------------------------
// updown_cnt_core
//   Loadable W-bit up/down counter. Load has priority over counting; the
//   count holds whenever en is low.
//
//   clk       in   system clock
//   rst       in   asynchronous active-high reset, clears count to 0
//   load      in   load load_val on the next edge
//   load_val  in   W-bit value to load
//   en        in   count enable
//   up        in   1 = increment, 0 = decrement
//   cnt       out  registered W-bit count
// ---------------------------------------------------------------------------
module updown_cnt_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= up ? cnt + W'(1) : cnt - W'(1);
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// updown_sweep_ctrl
//   Sequencer that runs an up/down counter through cmd_cycles triangle
//   sweeps lo -> hi -> lo with no dwell at either bound, then pulses done.
//   Commands arrive over a valid/ready handshake; a malformed command
//   (lo >= hi or zero cycles) is rejected with a one-cycle err pulse.
//   An abort in UP/DOWN returns to IDLE with count, direction and
//   cycles_left frozen.
//
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   cmd_valid    in   command present
//   cmd_ready    out  high exactly in IDLE
//   cmd_lo       in   lower sweep bound
//   cmd_hi       in   upper sweep bound
//   cmd_cycles   in   number of full lo->hi->lo sweeps
//   abort        in   stop the active sweep
//   cnt_out      out  current count value (registered)
//   dir_up       out  1 while counting up
//   busy         out  high in UP, DOWN and DONE
//   cycles_left  out  remaining sweeps including the current one
//   done         out  one-cycle pulse on completion
//   err          out  one-cycle pulse on command rejection
// ---------------------------------------------------------------------------
module updown_sweep_ctrl
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_lo,
  input  logic [W-1:0]  cmd_hi,
  input  logic [CW-1:0] cmd_cycles,
  input  logic          abort,
  output logic [W-1:0]  cnt_out,
  output logic          dir_up,
  output logic          busy,
  output logic [CW-1:0] cycles_left,
  output logic          done,
  output logic          err
);

  state_t       state;
  logic [W-1:0] lo_q;
  logic [W-1:0] hi_q;

  logic cmd_ok;
  logic cmd_take;
  logic at_top;
  logic at_bot;
  logic cnt_load;
  logic cnt_en;
  logic cnt_up;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  assign cmd_ok   = (cmd_lo < cmd_hi) && (cmd_cycles != '0);
  assign cmd_take = cmd_ready && cmd_valid;

  // Turn-around is decided one step early so the bound itself is reached
  // on the same edge that the direction flips: no dwell at hi or lo.
  // lo < hi is guaranteed for a running sweep, so neither expression wraps.
  assign at_top = (cnt_out == hi_q - W'(1));
  assign at_bot = (cnt_out == lo_q + W'(1));

  assign cnt_load = cmd_take && cmd_ok;
  assign cnt_en   = ((state == ST_UP) || (state == ST_DOWN)) && !abort;
  assign cnt_up   = (state == ST_UP);

  updown_cnt_core #(
    .W (W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cmd_lo),
    .en       (cnt_en),
    .up       (cnt_up),
    .cnt      (cnt_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      cycles_left <= '0;
      dir_up      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // abort is deliberately ignored here: a command arriving with
          // abort still high is accepted.
          if (cmd_valid) begin
            if (cmd_ok) begin
              lo_q        <= cmd_lo;
              hi_q        <= cmd_hi;
              cycles_left <= cmd_cycles;
              dir_up      <= 1'b1;
              state       <= ST_UP;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_UP: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (at_top) begin
            dir_up <= 1'b0;
            state  <= ST_DOWN;
          end
        end
        ST_DOWN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (at_bot) begin
            if (cycles_left == CW'(1)) begin
              cycles_left <= '0;
              done        <= 1'b1;
              state       <= ST_DONE;
            end else begin
              cycles_left <= cycles_left - CW'(1);
              dir_up      <= 1'b1;
              state       <= ST_UP;
            end
          end
        end
        ST_DONE: begin
          // done was raised on entry; this state lasts exactly one cycle.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
module tb_updown_sweep_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_lo;
  logic [W-1:0]  cmd_hi;
  logic [CW-1:0] cmd_cycles;
  logic          abort;
  logic [W-1:0]  cnt_out;
  logic          dir_up;
  logic          busy;
  logic [CW-1:0] cycles_left;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0]  cnt;
    logic          dir;
    logic [CW-1:0] cl;
    logic          done;
    logic          err;
    logic          busy;
  } exp_t;

  exp_t q[$];

  updown_sweep_ctrl #(.W(W), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_lo      (cmd_lo),
    .cmd_hi      (cmd_hi),
    .cmd_cycles  (cmd_cycles),
    .abort       (abort),
    .cnt_out     (cnt_out),
    .dir_up      (dir_up),
    .busy        (busy),
    .cycles_left (cycles_left),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int d, input int cl, input int dn, input int er, input int bz);
    exp_t e;
    e.cnt  = W'(c);
    e.dir  = 1'(d);
    e.cl   = CW'(cl);
    e.done = 1'(dn);
    e.err  = 1'(er);
    e.busy = 1'(bz);
    q.push_back(e);
  endtask

  // Expected post-edge samples for a complete accepted sweep set,
  // starting with the accept edge and ending with one IDLE sample.
  task automatic push_sweep(input int lo, input int hi, input int cyc);
    for (int c = cyc; c >= 1; c--) begin
      for (int v = lo; v < hi; v++) push(v, 1, c, 0, 0, 1);
      for (int v = hi; v > lo; v--) push(v, 0, c, 0, 0, 1);
    end
    push(lo, 0, 0, 1, 0, 1);
    push(lo, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(input int lo, input int hi, input int cyc);
    cmd_lo     = W'(lo);
    cmd_hi     = W'(hi);
    cmd_cycles = CW'(cyc);
    cmd_valid  = 1'b1;
  endtask

  task automatic step_check();
    exp_t e;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    e = q.pop_front();
    chk("cnt_out",     32'(cnt_out),     32'(e.cnt));
    chk("dir_up",      32'(dir_up),      32'(e.dir));
    chk("cycles_left", 32'(cycles_left), 32'(e.cl));
    chk("done",        32'(done),        32'(e.done));
    chk("err",         32'(err),         32'(e.err));
    chk("busy",        32'(busy),        32'(e.busy));
    chk("cmd_ready",   32'(cmd_ready),   32'(!e.busy));
  endtask

  task automatic drain();
    while (q.size() > 0) step_check();
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_lo     = '0;
    cmd_hi     = '0;
    cmd_cycles = '0;
    abort      = 1'b0;

    // Reset state
    #2;
    chk("rst_cnt",  32'(cnt_out),     32'd0);
    chk("rst_dir",  32'(dir_up),      32'd0);
    chk("rst_cl",   32'(cycles_left), 32'd0);
    chk("rst_busy", 32'(busy),        32'd0);
    chk("rst_done", 32'(done),        32'd0);
    chk("rst_err",  32'(err),         32'd0);
    #11;
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic single sweep 2..5
    issue(2, 5, 1);
    push_sweep(2, 5, 1);
    drain();

    // Narrow sweep, three repetitions
    issue(7, 8, 3);
    push_sweep(7, 8, 3);
    drain();

    // Rejected commands: err pulse, IDLE kept, cnt_out holds 7
    issue(5, 5, 1);
    push(7, 0, 0, 0, 1, 0);
    push(7, 0, 0, 0, 0, 0);
    drain();
    issue(9, 3, 1);
    push(7, 0, 0, 0, 1, 0);
    push(7, 0, 0, 0, 0, 0);
    drain();
    issue(0, 4, 0);
    push(7, 0, 0, 0, 1, 0);
    push(7, 0, 0, 0, 0, 0);
    drain();

    // Full range, no wrap
    issue(0, 15, 1);
    push_sweep(0, 15, 1);
    drain();

    // Abort in DOWN at cnt_out=4 of a 1..6 sweep
    issue(1, 6, 2);
    for (int v = 1; v < 6; v++) push(v, 1, 2, 0, 0, 1);
    push(6, 0, 2, 0, 0, 1);
    push(5, 0, 2, 0, 0, 1);
    push(4, 0, 2, 0, 0, 1);
    drain();
    abort = 1'b1;
    push(4, 0, 2, 0, 0, 0);
    drain();
    // New command next cycle, abort still high in IDLE: must be accepted
    issue(3, 4, 1);
    push_sweep(3, 4, 1);
    step_check();
    abort = 1'b0;
    drain();

    // Asynchronous reset mid-sweep during UP
    issue(0, 10, 1);
    push(0, 1, 1, 0, 0, 1);
    push(1, 1, 1, 0, 0, 1);
    push(2, 1, 1, 0, 0, 1);
    drain();
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt",   32'(cnt_out),     32'd0);
    chk("mid_rst_dir",   32'(dir_up),      32'd0);
    chk("mid_rst_cl",    32'(cycles_left), 32'd0);
    chk("mid_rst_busy",  32'(busy),        32'd0);
    chk("mid_rst_done",  32'(done),        32'd0);
    chk("mid_rst_ready", 32'(cmd_ready),   32'd1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_cnt",  32'(cnt_out), 32'd0);
    issue(2, 5, 1);
    push_sweep(2, 5, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer that drives a W-bit up/down counter datapath through programmed triangle sweeps: lo -> hi -> lo, repeated N times.
- Accepts one command at a time over a valid/ready handshake and reports completion, abort and error.
- Sits between a control/register block and any logic consuming the swept count value, such as a DAC or address stepper.

Parameters:
- W, 4, counter and bound width.
- CW, 8, width of the sweep-count field.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high exactly when the state is IDLE (combinational from state).
- cmd_lo  input  W  lower sweep bound.
- cmd_hi  input  W  upper sweep bound.
- cmd_cycles  input  CW  number of full lo->hi->lo sweeps.
- abort  input  1  stop the active sweep.
- cnt_out  output  W  current count value, registered.
- dir_up  output  1  1 while counting up, 0 otherwise.
- busy  output  1  high in the UP, DOWN and DONE states.
- cycles_left  output  CW  remaining sweeps, including the current one.
- done  output  1  one-cycle pulse when the sweep set completes.
- err  output  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset values:
  - state = IDLE, cnt_out = 0, dir_up = 0, cycles_left = 0, done = 0, err = 0, busy = 0.
  - cmd_ready = 1 once reset is released.
- States: IDLE, UP, DOWN, DONE.
- IDLE, on a cycle where cmd_valid && cmd_ready:
  - If cmd_lo >= cmd_hi, or cmd_cycles == 0: at the next edge err = 1 for one cycle. State stays IDLE. cnt_out and cycles_left are unchanged.
  - Otherwise, at the next edge: bounds latched, cnt_out <= cmd_lo, cycles_left <= cmd_cycles, dir_up <= 1, state <= UP.
- UP:
  - cnt_out increments by 1 per cycle.
  - When cnt_out == hi-1: cnt_out <= hi, dir_up <= 0, state <= DOWN.
- DOWN:
  - cnt_out decrements by 1 per cycle.
  - When cnt_out == lo+1: cnt_out <= lo.
    - If cycles_left == 1: state <= DONE, cycles_left <= 0.
    - Else: cycles_left decrements, dir_up <= 1, state <= UP.
- DONE:
  - done = 1 for exactly this one cycle; cnt_out holds lo.
  - Next edge: state <= IDLE.
- Timing:
  - No dwell at either bound.
  - One sweep occupies 2*(hi-lo) cycles in UP/DOWN, plus 1 cycle in DONE.
  - The count never wraps: lo < hi is guaranteed, so values stay within [lo, hi].
- Abort:
  - abort high in UP or DOWN: next edge state <= IDLE. cnt_out, dir_up and cycles_left hold their current values. No done pulse.
  - abort in IDLE or DONE is ignored. DONE still completes and pulses done.
  - abort together with cmd_valid in IDLE: the command is accepted.
- cmd_valid while busy is not accepted, because cmd_ready = 0.
- Reset asserted mid-sweep: all outputs return to their reset values asynchronously. No done pulse is generated.
- In IDLE, cnt_out holds its last value.
- Latched bounds are internal registers; the cmd_* inputs are sampled only at accept.

Decomposition:
- Shared package:
  - State enum (IDLE, UP, DOWN, DONE).
  - Default widths W and CW.
- One sub-module: updown_cnt_core.
  - Inputs: clk, rst, load, load_val, en, up.
  - Output: registered W-bit count.
  - Holds when en = 0.
- The controller FSM drives load, en and up, and owns the bounds, cycles_left, done and err.

Test Plan:
- lo=2, hi=5, cycles=1, accepted at edge 0:
  - cnt_out after edges 0..6 = 2,3,4,5,4,3,2.
  - dir_up = 1 through edge 2, 0 from edge 3.
  - done = 1 in the cycle after edge 6; cmd_ready = 1 after edge 7.
- lo=7, hi=8, cycles=3:
  - cnt_out alternates 7,8,7,8,7,8,7.
  - cycles_left steps 3,2,1,0.
  - Exactly one done pulse.
- Bad commands, each -> err pulse once, state stays IDLE, cnt_out unchanged:
  - lo=5, hi=5.
  - lo=9, hi=3.
  - lo=0, hi=4, cycles=0.
- Full range lo=0, hi=15, cycles=1:
  - cnt_out reaches 15 and returns to 0 without wrap.
  - 30 cycles in UP/DOWN, then done.
- Abort and back-to-back commands:
  - Abort asserted while cnt_out=4 in DOWN of a lo=1, hi=6 sweep -> IDLE next edge, cnt_out holds 4, no done.
  - A new command is accepted on the following cycle.
- Reset mid-sweep:
  - rst pulsed asynchronously (not on a clock edge) during UP -> outputs immediately 0, cmd_ready = 1.
  - A subsequent command runs normally.
